onehot_event_decoder: RTL and testbench

Receive-side counterpart of the 8-to-3 priority encoder. It accepts encoded event indices (3-bit index plus valid), records them in an 8-bit pending mask, and re-expands them one at a time into one-hot event lines toward the consumer. Pending events are served highest index first, so the encoder's MSB-priority order is kept end to end. A valid/ready handshake on the consumer side is followed by a programmable inter-event gap.

---
 rtl/onehot_event_decoder_if.sv | 23 ++
 rtl/onehot_event_decoder.sv | 114 +++++++++++
 tb/tb_onehot_event_decoder.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/onehot_event_decoder_if.sv
// Event bus for onehot_event_decoder: encoded input side, one-hot output
// handshake side, and status observation signals.
interface onehot_event_decoder_if;
    logic [2:0] in_idx;
    logic       in_valid;
    logic [7:0] out;
    logic [2:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] pending;
    logic       busy;
    logic [7:0] merge_cnt;

    modport master (
        output in_idx, in_valid, out_ready,
        input  out, out_idx, out_valid, pending, busy, merge_cnt
    );

    modport slave (
        input  in_idx, in_valid, out_ready,
        output out, out_idx, out_valid, pending, busy, merge_cnt
    );
endinterface

// File: rtl/onehot_event_decoder.sv
// Receive-side decoder: encoded event indices are collected in a pending mask and
// re-expanded one at a time, highest index first, onto a one-hot handshake bus.
module onehot_event_decoder #(
    parameter int unsigned GAP_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    onehot_event_decoder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, PRESENT, GAP} state_t;

    localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

    state_t     state_q, state_d;
    logic [7:0] out_q, out_d;
    logic [2:0] idx_q, idx_d;
    logic       valid_q, valid_d;
    logic [7:0] pend_q, pend_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] merge_q, merge_d;
    logic       busy_q;
    logic [2:0] sel;
    logic       load;
    logic [7:0] clr;
    logic [7:0] set;

    always_comb begin
        sel = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (pend_q[i]) sel = 3'(i);
        end

        state_d = state_q;
        out_d   = out_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        gap_d   = gap_q;
        load    = 1'b0;
        clr     = '0;

        case (state_q)
            IDLE: begin
                if (|pend_q) load = 1'b1;
            end
            PRESENT: begin
                if (valid_q && bus.out_ready) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
                        out_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end else if (|pend_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                        out_d   = '0;
                        idx_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end
            GAP: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = PRESENT;
            out_d   = 8'b1 << sel;
            idx_d   = sel;
            valid_d = 1'b1;
            clr     = 8'b1 << sel;
        end

        // Set is ORed after the clear so a same-cycle re-arrival of the loaded index survives.
        set     = bus.in_valid ? (8'b1 << bus.in_idx) : '0;
        pend_d  = (pend_q & ~clr) | set;
        merge_d = merge_q;
        if (bus.in_valid && pend_q[bus.in_idx] && !clr[bus.in_idx] && merge_q != '1)
            merge_d = merge_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= '0;
            gap_q   <= '0;
            merge_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            gap_q   <= gap_d;
            merge_q <= merge_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    assign bus.out       = out_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.pending   = pend_q;
    assign bus.busy      = busy_q;
    assign bus.merge_cnt = merge_q;
endmodule

// File: tb/tb_onehot_event_decoder.sv
// Scoreboard bench for onehot_event_decoder: one instance with a 2-cycle gap and
// one with no gap, driven on the falling edge and sampled on the falling edge.
module tb_onehot_event_decoder;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    logic [2:0] sb[$];

    onehot_event_decoder_if i2 ();
    onehot_event_decoder_if i0 ();

    onehot_event_decoder #(.GAP_CYCLES(2)) dut_g2 (.clk(clk), .rst(rst), .bus(i2));
    onehot_event_decoder #(.GAP_CYCLES(0)) dut_g0 (.clk(clk), .rst(rst), .bus(i0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i2.in_valid = 1'b0; i2.in_idx = '0; i2.out_ready = 1'b0;
        i0.in_valid = 1'b0; i0.in_idx = '0; i0.out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({i2.out, i2.out_idx, i2.out_valid, i2.pending, i2.busy, i2.merge_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_g2 got out=%b idx=%0d v=%b pend=%b busy=%b merge=%0d want all 0",
                     i2.out, i2.out_idx, i2.out_valid, i2.pending, i2.busy, i2.merge_cnt);
        end
        checks++;
        if ({i0.out, i0.out_idx, i0.out_valid, i0.pending, i0.busy, i0.merge_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_g0 got out=%b v=%b pend=%b busy=%b want all 0",
                     i0.out, i0.out_valid, i0.pending, i0.busy);
        end
    endtask

    task automatic test_single();
        logic [2:0] exp;
        do_reset();
        i2.out_ready = 1'b1;
        i2.in_idx = 3'd5; i2.in_valid = 1'b1;
        sb.push_back(3'd5);
        tick();
        i2.in_valid = 1'b0;
        checks++;
        if (i2.pending !== 8'b00100000 || i2.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_c1 got pend=%b v=%b want pend=00100000 v=0", i2.pending, i2.out_valid);
        end
        tick();
        exp = sb.pop_front();
        checks++;
        if (i2.out_valid !== 1'b1 || i2.out_idx !== exp || i2.out !== (8'b1 << exp) || i2.busy !== 1'b1) begin
            failures++;
            $display("FAIL single_c2 got v=%b idx=%0d out=%b busy=%b want v=1 idx=%0d busy=1",
                     i2.out_valid, i2.out_idx, i2.out, i2.busy, exp);
        end
        for (int c = 3; c <= 4; c++) begin
            tick();
            checks++;
            if (i2.out_valid !== 1'b0 || i2.out !== 8'h00 || i2.busy !== 1'b1) begin
                failures++;
                $display("FAIL single_gap_c%0d got v=%b out=%b busy=%b want v=0 out=0 busy=1",
                         c, i2.out_valid, i2.out, i2.busy);
            end
        end
        tick();
        checks++;
        if (i2.busy !== 1'b0 || i2.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_c5 got busy=%b v=%b want busy=0 v=0", i2.busy, i2.out_valid);
        end
    endtask

    task automatic test_priority();
        logic [2:0] exp;
        do_reset();
        i2.out_ready = 1'b0;
        i2.in_valid = 1'b1;
        i2.in_idx = 3'd1; sb.push_back(3'd1); tick();
        i2.in_idx = 3'd7; sb.push_back(3'd7); tick();
        i2.in_idx = 3'd3; sb.push_back(3'd3); tick();
        i2.in_valid = 1'b0;
        checks++;
        if (i2.pending !== 8'b10001000 || i2.out_idx !== 3'd1 || i2.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL prio_fill got pend=%b idx=%0d v=%b want pend=10001000 idx=1 v=1",
                     i2.pending, i2.out_idx, i2.out_valid);
        end
        i2.out_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            if (i2.out_valid && i2.out_ready) begin
                exp = sb.pop_front();
                checks++;
                if (i2.out_idx !== exp || i2.out !== (8'b1 << exp)) begin
                    failures++;
                    $display("FAIL prio_order got idx=%0d out=%b want idx=%0d", i2.out_idx, i2.out, exp);
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL prio_timeout got %0d outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] exp;
        do_reset();
        i2.out_ready = 1'b0;
        i2.in_idx = 3'd4; i2.in_valid = 1'b1; sb.push_back(3'd4);
        tick();
        i2.in_valid = 1'b0;
        tick();
        for (int c = 0; c < 10; c++) begin
            i2.in_valid = (c < 2);
            i2.in_idx   = (c == 0) ? 3'd2 : 3'd6;
            checks++;
            if (i2.out !== 8'b00010000 || i2.out_valid !== 1'b1 || i2.out_idx !== 3'd4) begin
                failures++;
                $display("FAIL bp_hold_%0d got out=%b v=%b idx=%0d want out=00010000 v=1 idx=4",
                         c, i2.out, i2.out_valid, i2.out_idx);
            end
            tick();
        end
        i2.in_valid = 1'b0;
        checks++;
        if (i2.pending !== 8'b01000100) begin
            failures++;
            $display("FAIL bp_pending got %b want 01000100", i2.pending);
        end
        sb.push_back(3'd6);
        sb.push_back(3'd2);
        i2.out_ready = 1'b1;
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            if (i2.out_valid && i2.out_ready) begin
                exp = sb.pop_front();
                checks++;
                if (i2.out_idx !== exp || i2.out !== (8'b1 << exp)) begin
                    failures++;
                    $display("FAIL bp_order got idx=%0d out=%b want idx=%0d", i2.out_idx, i2.out, exp);
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout got %0d outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_merge();
        logic [2:0] exp;
        do_reset();
        i2.out_ready = 1'b0;
        i2.in_idx = 3'd4; i2.in_valid = 1'b1; sb.push_back(3'd4);
        tick();
        i2.in_valid = 1'b0;
        tick();
        // Index 4 now held; two arrivals of 2 set then merge.
        i2.in_idx = 3'd2; i2.in_valid = 1'b1; tick();
        tick();
        i2.in_valid = 1'b0;
        checks++;
        if (i2.merge_cnt !== 8'd1 || i2.pending !== 8'b00000100) begin
            failures++;
            $display("FAIL merge_cnt got merge=%0d pend=%b want merge=1 pend=00000100",
                     i2.merge_cnt, i2.pending);
        end
        exp = sb.pop_front();
        checks++;
        if (i2.out_idx !== exp || i2.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL merge_present got idx=%0d v=%b want idx=%0d v=1", i2.out_idx, i2.out_valid, exp);
        end
        i2.out_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if (i2.busy !== 1'b0 || i2.pending !== 8'b00000100) begin
            failures++;
            $display("FAIL merge_idle got busy=%b pend=%b want busy=0 pend=00000100", i2.busy, i2.pending);
        end
        i2.in_idx = 3'd2; i2.in_valid = 1'b1;
        sb.push_back(3'd2);
        sb.push_back(3'd2);
        tick();
        i2.in_valid = 1'b0;
        checks++;
        if (i2.pending !== 8'b00000100 || i2.merge_cnt !== 8'd1 || i2.out_idx !== 3'd2 || i2.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL merge_setclr got pend=%b merge=%0d idx=%0d v=%b want pend=00000100 merge=1 idx=2 v=1",
                     i2.pending, i2.merge_cnt, i2.out_idx, i2.out_valid);
        end
        for (int c = 0; c < 100 && sb.size() > 0; c++) begin
            if (i2.out_valid && i2.out_ready) begin
                exp = sb.pop_front();
                checks++;
                if (i2.out_idx !== exp || i2.out !== (8'b1 << exp)) begin
                    failures++;
                    $display("FAIL merge_order got idx=%0d out=%b want idx=%0d", i2.out_idx, i2.out, exp);
                end
            end
            tick();
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL merge_timeout got %0d outstanding want 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] exp;
        logic [2:0] seq[9];
        seq = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        do_reset();
        i0.out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            i0.in_idx = seq[c]; i0.in_valid = 1'b1;
            tick();
        end
        i0.in_valid = 1'b0;
        checks++;
        if (i0.pending !== 8'b11111111 || i0.merge_cnt !== 8'd0 || i0.out_idx !== 3'd7) begin
            failures++;
            $display("FAIL b2b_fill got pend=%b merge=%0d idx=%0d want pend=11111111 merge=0 idx=7",
                     i0.pending, i0.merge_cnt, i0.out_idx);
        end
        sb.push_back(3'd7);
        for (int k = 7; k >= 0; k--) sb.push_back(3'(k));
        i0.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            exp = sb.pop_front();
            checks++;
            if (i0.out_valid !== 1'b1 || i0.out_idx !== exp || i0.out !== (8'b1 << exp)) begin
                failures++;
                $display("FAIL b2b_cycle%0d got v=%b idx=%0d out=%b want v=1 idx=%0d",
                         c, i0.out_valid, i0.out_idx, i0.out, exp);
            end
            tick();
        end
        checks++;
        if (i0.out_valid !== 1'b0 || i0.busy !== 1'b0 || i0.out !== 8'h00) begin
            failures++;
            $display("FAIL b2b_end got v=%b busy=%b out=%b want v=0 busy=0 out=0",
                     i0.out_valid, i0.busy, i0.out);
        end
        sb.delete();
    endtask

    task automatic test_reset_mid_present();
        int stray;
        do_reset();
        i2.out_ready = 1'b0;
        i2.in_valid = 1'b1;
        i2.in_idx = 3'd4; tick();
        i2.in_idx = 3'd2; tick();
        i2.in_idx = 3'd1; tick();
        i2.in_valid = 1'b0;
        checks++;
        if (i2.out !== 8'b00010000 || i2.out_valid !== 1'b1 || i2.pending !== 8'b00000110) begin
            failures++;
            $display("FAIL rstmid_setup got out=%b v=%b pend=%b want out=00010000 v=1 pend=00000110",
                     i2.out, i2.out_valid, i2.pending);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({i2.out, i2.out_idx, i2.out_valid, i2.pending, i2.busy, i2.merge_cnt} !== '0) begin
            failures++;
            $display("FAIL rstmid_clear got out=%b v=%b pend=%b busy=%b want all 0",
                     i2.out, i2.out_valid, i2.pending, i2.busy);
        end
        i2.out_ready = 1'b1;
        stray = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (i2.out_valid !== 1'b0 || i2.busy !== 1'b0) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL rstmid_quiet got %0d active cycles want 0", stray);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        i2.in_valid = 1'b0; i2.in_idx = '0; i2.out_ready = 1'b0;
        i0.in_valid = 1'b0; i0.in_idx = '0; i0.out_ready = 1'b0;
        tick();
        test_reset();
        test_single();
        test_priority();
        test_backpressure();
        test_merge();
        test_back_to_back();
        test_reset_mid_present();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end
endmodule
